// File: rtl/load_store_unit_pkg.sv
// Shared RV32 definitions for the memory stage: funct3 codes, FSM states, XLEN.
// Also holds the funct3 legality and alignment helpers.
package riscv_defs;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    if (st)
      return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW,
                      F3_LBU, F3_LHU};
  endfunction

  // Size lives in funct3[1:0] for loads and stores alike.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return (f3[1:0] == 2'b01 && a[0]) ||
           (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute request, data-memory bus and register-file write port of the LSU.
// master = the unit itself, slave = its environment.
interface load_store_unit_if
  import riscv_defs::*;
  ;

  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  logic            WE3;
  logic [4:0]      WA3;
  logic [XLEN-1:0] WD3;
  logic            busy;
  logic            err;

  modport master (
    input  req_valid, req_is_store, req_funct3,
    input  req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    output WE3, WA3, WD3, busy, err
  );

  modport slave (
    output req_valid, req_is_store, req_funct3,
    output req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    input  WE3, WA3, WD3, busy, err
  );

endinterface

// File: rtl/load_store_unit_extend.sv
// Load data alignment: picks the byte/half lane of the read word and
// sign- or zero-extends it according to funct3.
module load_extend
  import riscv_defs::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr, 3'b000} +: 8];
    h    = addr[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LBU:  data = {24'd0, b};
      F3_LHU:  data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 memory stage: req/ack data access, load extend, RF port-3 writeback.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            is_store;
  logic [2:0]      funct3;
  logic [1:0]      lane;
  logic [4:0]      rd;
  logic [XLEN-1:0] ld_data;
  logic            ok;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;

  load_extend u_ext (
    .rdata  (bus.mem_rdata),
    .addr   (lane),
    .funct3 (funct3),
    .data   (ld_data)
  );

  always_comb begin
    ok = f3_legal(bus.req_is_store, bus.req_funct3);
`ifdef MISALIGN_TRAP_EN
    if (misaligned(bus.req_funct3, bus.req_addr[1:0]))
      ok = 1'b0;
`endif
  end

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = bus.req_wdata;
    unique case (1'b1)
      (bus.req_funct3 == F3_SB): begin
        st_be    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      (bus.req_funct3 == F3_SH): begin
        st_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      (bus.req_funct3 == F3_SW): st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      is_store      <= 1'b0;
      funct3        <= '0;
      lane          <= '0;
      rd            <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.WE3       <= 1'b0;
      bus.WA3       <= '0;
      bus.WD3       <= '0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      bus.WE3 <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (!ok) begin
              bus.err <= 1'b1;
            end else begin
              state         <= S_ACCESS;
              wait_cnt      <= '0;
              is_store      <= bus.req_is_store;
              funct3        <= bus.req_funct3;
              lane          <= bus.req_addr[1:0];
              rd            <= bus.req_rd;
              bus.req_ready <= 1'b0;
              bus.busy      <= 1'b1;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_is_store;
              bus.mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
              bus.mem_wdata <= st_wdata;
              bus.mem_be    <= bus.req_is_store ? st_be : 4'b0000;
            end
          end
        end
        S_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.mem_be  <= 4'b0000;
            if (is_store) begin
              state         <= S_IDLE;
              bus.req_ready <= 1'b1;
              bus.busy      <= 1'b0;
            end else begin
              state   <= S_WB;
              bus.WE3 <= (rd != 5'd0);
              bus.WA3 <= rd;
              bus.WD3 <= ld_data;
            end
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            state         <= S_IDLE;
            bus.err       <= 1'b1;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        S_WB: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, rd=0, timeout,
// illegal funct3, busy-ignore and asynchronous reset mid-access.
module tb_load_store_unit;
  import riscv_defs::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   cnt;
  logic we_seen;

  load_store_unit_if bus ();

  load_store_unit #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [4:0] r);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = r;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  // Single-cycle-ack load; expected data is hand-computed by the caller.
  task automatic load(input string tag,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [4:0] r,
                      input logic [31:0] rdata,
                      input logic [31:0] exp_wd);
    issue(1'b0, f3, a, 32'h0, r);
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_be"}, 32'(bus.mem_be), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk({tag, "_we3"}, 32'(bus.WE3), 32'(r != 5'd0));
    chk({tag, "_busy_wb"}, 32'(bus.busy), 32'd1);
    if (r != 5'd0) begin
      chk({tag, "_wa3"}, 32'(bus.WA3), 32'(r));
      chk({tag, "_wd3"}, bus.WD3, exp_wd);
    end
    @(negedge clk);
    chk({tag, "_we3_off"}, 32'(bus.WE3), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_rd       = 5'd0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we3", 32'(bus.WE3), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // SW, ack on the second ACCESS cycle, with a request arriving mid-flight
    issue(1'b1, F3_SW, 32'h100, 32'h12345678, 5'd0);
    chk("sw_req", 32'(bus.mem_req), 32'd1);
    chk("sw_we", 32'(bus.mem_we), 32'd1);
    chk("sw_be", 32'(bus.mem_be), 32'hF);
    chk("sw_addr", bus.mem_addr, 32'h100);
    chk("sw_wdata", bus.mem_wdata, 32'h12345678);
    chk("sw_ready", 32'(bus.req_ready), 32'd0);
    chk("sw_busy", 32'(bus.busy), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = F3_LW;
    bus.req_addr     = 32'h400;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("sw_hold_addr", bus.mem_addr, 32'h100);
    chk("sw_hold_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("sw_done_req", 32'(bus.mem_req), 32'd0);
    chk("sw_done_ready", 32'(bus.req_ready), 32'd1);
    chk("sw_no_we3", 32'(bus.WE3), 32'd0);
    chk("sw_done_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("busy_not_queued", 32'(bus.mem_req), 32'd0);

    load("lb", F3_LB, 32'h103, 5'd9, 32'h80FF1234, 32'hFFFFFF80);
    load("lbu", F3_LBU, 32'h103, 5'd9, 32'h80FF1234, 32'h00000080);
    load("lb1", F3_LB, 32'h101, 5'd2, 32'h80FF1234, 32'h00000012);
    load("lh", F3_LH, 32'h102, 5'd5, 32'h80FF1234, 32'hFFFF80FF);
    load("lhu", F3_LHU, 32'h100, 5'd6, 32'h80FF9234, 32'h00009234);
    load("lw_rd0", F3_LW, 32'h104, 5'd0, 32'hDEADBEEF, 32'h0);

    // SH upper half
    issue(1'b1, F3_SH, 32'h102, 32'h0000ABCD, 5'd0);
    chk("sh_be", 32'(bus.mem_be), 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'hABCDABCD);
    chk("sh_addr", bus.mem_addr, 32'h100);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);

    // SB lane 1
    issue(1'b1, F3_SB, 32'h201, 32'h1234565A, 5'd0);
    chk("sb_be", 32'(bus.mem_be), 32'h2);
    chk("sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
    chk("sb_addr", bus.mem_addr, 32'h200);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);

    // Timeout: 15 cycles of mem_req, then an err pulse
    issue(1'b0, F3_LW, 32'h200, 32'h0, 5'd3);
    cnt     = 0;
    we_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.mem_req) break;
      cnt++;
      we_seen |= bus.WE3;
      @(negedge clk);
    end
    chk("to_cycles", 32'(cnt), 32'd15);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_req", 32'(bus.mem_req), 32'd0);
    chk("to_we3_seen", 32'(we_seen | bus.WE3), 32'd0);
    @(negedge clk);
    chk("to_err_pulse", 32'(bus.err), 32'd0);
    chk("to_ready", 32'(bus.req_ready), 32'd1);
    chk("to_we3", 32'(bus.WE3), 32'd0);

    // Ack on the last allowed cycle still succeeds
    issue(1'b0, F3_LW, 32'h300, 32'h0, 5'd7);
    repeat (14) @(negedge clk);
    chk("late_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11223344;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_err", 32'(bus.err), 32'd0);
    chk("late_we3", 32'(bus.WE3), 32'd1);
    chk("late_wd3", bus.WD3, 32'h11223344);
    @(negedge clk);

    // Illegal funct3, load and store
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd1);
    chk("ill_ld_err", 32'(bus.err), 32'd1);
    chk("ill_ld_req", 32'(bus.mem_req), 32'd0);
    chk("ill_ld_ready", 32'(bus.req_ready), 32'd1);
    chk("ill_ld_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("ill_ld_pulse", 32'(bus.err), 32'd0);
    issue(1'b1, 3'b100, 32'h100, 32'h0, 5'd0);
    chk("ill_st_err", 32'(bus.err), 32'd1);
    chk("ill_st_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);

`ifdef MISALIGN_TRAP_EN
    issue(1'b0, F3_LW, 32'h102, 32'h0, 5'd8);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_req", 32'(bus.mem_req), 32'd0);
    chk("mis_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("mis_we3", 32'(bus.WE3), 32'd0);
`else
    load("mis_lw", F3_LW, 32'h102, 5'd8, 32'hCAFEF00D, 32'hCAFEF00D);
`endif

    // Asynchronous reset in the middle of ACCESS
    issue(1'b0, F3_LW, 32'h500, 32'h0, 5'd4);
    chk("ar_req_before", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req", 32'(bus.mem_req), 32'd0);
    chk("ar_ready", 32'(bus.req_ready), 32'd1);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_we3", 32'(bus.WE3), 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("ar_post_we3", 32'(bus.WE3), 32'd0);
    chk("ar_post_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("ar_post_we3_2", 32'(bus.WE3), 32'd0);
    chk("ar_post_ready", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
